prbs_checker: RTL and testbench

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_pkg.sv | 19 +
 rtl/lfsr_feedback.sv | 13 +
 rtl/prbs_checker.sv | 123 ++++++++++++
 tb/tb_prbs_checker.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker state encoding and standard tap masks.
// Reused by both the checker and any matching generator.
package prbs_pkg;

    typedef enum logic [1:0] {
        ST_SEED    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } prbs_state_t;

    // Tap masks: bit i corresponds to LFSR stage i+1.
    localparam logic [6:0]  PRBS7_TAPS  = 7'b1100000;            // x^7 + x^6 + 1
    localparam logic [14:0] PRBS15_TAPS = 15'b110000000000000;   // x^15 + x^14 + 1

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/lfsr_feedback.sv
// Fibonacci LFSR feedback bit: XOR of the tapped stages of the shift register.
// Shared by the checker (bit prediction) and the generator (next output bit).
module lfsr_feedback #(
    parameter int unsigned     BITS = 7,
    parameter logic [BITS-1:0] TAPS = 7'b1100000
) (
    input  logic [BITS-1:0] sreg,
    output logic            fb
);

    assign fb = ^(sreg & TAPS);

endmodule

// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-seeds from the incoming stream, acquires lock after a
// run of correct predictions, then counts bit errors until too many in a row occur.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int unsigned     BITS         = 7,
    parameter logic [BITS-1:0] TAPS         = PRBS7_TAPS,
    parameter int unsigned     LOCK_MATCHES = 16,
    parameter int unsigned     LOSS_ERRS    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data,
    input  logic        data_valid,
    input  logic        clear,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count
);

    localparam logic [4:0] FILL_FULL   = 5'(BITS);
    localparam logic [7:0] LOCK_TARGET = 8'(LOCK_MATCHES);
    localparam logic [3:0] LOSS_TARGET = 4'(LOSS_ERRS);

    prbs_state_t     state;
    logic [BITS-1:0] sreg;
    logic [4:0]      fill_cnt;
    logic [7:0]      match_cnt;
    logic [3:0]      miss_cnt;

    logic            predicted;
    logic            shift_bit;
    logic            mismatch;
    logic [BITS-1:0] sreg_shift;
    logic [4:0]      fill_next;
    logic [7:0]      match_inc;
    logic [3:0]      miss_inc;

    lfsr_feedback #(
        .BITS (BITS),
        .TAPS (TAPS)
    ) u_feedback (
        .sreg (sreg),
        .fb   (predicted)
    );

    // Once locked the local LFSR free-runs on its own prediction, so a corrupted
    // received bit is reported once instead of poisoning the next BITS predictions.
    always_comb begin
        shift_bit  = (state == ST_LOCKED) ? predicted : data;
        sreg_shift = {sreg[BITS-2:0], shift_bit};
        mismatch   = data ^ predicted;
        fill_next  = (fill_cnt == FILL_FULL) ? fill_cnt : fill_cnt + 5'd1;
        match_inc  = match_cnt + 8'd1;
        miss_inc   = miss_cnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_SEED;
            sreg      <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (clear) begin
                err_count <= '0;
            end
            if (data_valid) begin
                sreg <= sreg_shift;
                case (state)
                    ST_SEED: begin
                        fill_cnt <= fill_next;
                        // An all-zero seed is a lockup state; keep shifting until it clears.
                        if (fill_next == FILL_FULL && sreg_shift != '0) begin
                            state     <= ST_ACQUIRE;
                            match_cnt <= '0;
                        end
                    end
                    ST_ACQUIRE: begin
                        if (mismatch) begin
                            match_cnt <= '0;
                        end else begin
                            match_cnt <= match_inc;
                            if (match_inc == LOCK_TARGET) begin
                                state    <= ST_LOCKED;
                                locked   <= 1'b1;
                                miss_cnt <= '0;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (mismatch) begin
                            err_pulse <= 1'b1;
                            if (!clear) begin
                                err_count <= sat_inc16(err_count);
                            end
                            if (miss_inc == LOSS_TARGET) begin
                                state    <= ST_SEED;
                                locked   <= 1'b0;
                                fill_cnt <= '0;
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_inc;
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                    default: begin
                        state  <= ST_SEED;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: queue-based reference model plus directed
// scenarios, and a second instance driven into err_count saturation.
module tb_prbs_checker;
    import prbs_pkg::*;

    localparam int BITS   = 7;
    localparam int LOCK_M = 16;
    localparam int LOSS_E = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, data, data_valid, clear;
    logic        locked, err_pulse;
    logic [15:0] err_count;

    logic        s_rst_n, s_data, s_data_valid, s_clear;
    logic        s_locked, s_err_pulse;
    logic [15:0] s_err_count;

    prbs_checker #(
        .BITS         (BITS),
        .TAPS         (PRBS7_TAPS),
        .LOCK_MATCHES (LOCK_M),
        .LOSS_ERRS    (LOSS_E)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .data_valid (data_valid),
        .clear      (clear),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_count  (err_count)
    );

    prbs_checker #(
        .BITS         (BITS),
        .TAPS         (PRBS7_TAPS),
        .LOCK_MATCHES (LOCK_M),
        .LOSS_ERRS    (15)
    ) dut_sat (
        .clk        (clk),
        .rst_n      (s_rst_n),
        .data       (s_data),
        .data_valid (s_data_valid),
        .clear      (s_clear),
        .locked     (s_locked),
        .err_pulse  (s_err_pulse),
        .err_count  (s_err_count)
    );

    int errors = 0;
    int checks = 0;
    bit main_done = 0;
    bit sat_done  = 0;

    typedef struct packed {
        logic        locked;
        logic        pulse;
        logic [15:0] count;
    } exp_t;
    exp_t sb[$];

    logic [6:0] taps = PRBS7_TAPS;

    // Reference model: history queue (index 0 = newest bit) and plain counters.
    int m_mode;          // 0 seeding, 1 acquiring, 2 locked
    bit m_hist[$];
    int m_fill, m_match, m_miss, m_errs;
    bit m_pulse;

    function automatic bit m_predict();
        bit p = 1'b0;
        for (int i = 0; i < BITS; i++)
            if (taps[i]) p ^= m_hist[i];
        return p;
    endfunction

    function automatic bit m_nonzero();
        for (int i = 0; i < BITS; i++)
            if (m_hist[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_shift(input bit b);
        m_hist.push_front(b);
        void'(m_hist.pop_back());
    endtask

    task automatic model_step(input bit r, input bit v, input bit d, input bit c);
        bit p;
        m_pulse = 1'b0;
        if (!r) begin
            m_mode = 0;
            m_hist = {};
            repeat (BITS) m_hist.push_back(1'b0);
            m_fill = 0; m_match = 0; m_miss = 0; m_errs = 0;
            return;
        end
        if (v) begin
            p = m_predict();
            case (m_mode)
                0: begin
                    m_shift(d);
                    if (m_fill < BITS) m_fill++;
                    if (m_fill == BITS && m_nonzero()) begin
                        m_mode = 1; m_match = 0;
                    end
                end
                1: begin
                    m_shift(d);
                    m_match = (d == p) ? m_match + 1 : 0;
                    if (m_match == LOCK_M) begin
                        m_mode = 2; m_miss = 0;
                    end
                end
                default: begin
                    m_shift(p);
                    if (d != p) begin
                        m_pulse = 1'b1;
                        if (m_errs < 65535) m_errs++;
                        m_miss++;
                        if (m_miss == LOSS_E) begin
                            m_mode = 0; m_fill = 0;
                        end
                    end else begin
                        m_miss = 0;
                    end
                end
            endcase
        end
        if (c) m_errs = 0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: one expectation per clock, compared after the edge it describes.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (locked !== e.locked || err_pulse !== e.pulse || err_count !== e.count) begin
                errors++;
                $display("FAIL scoreboard @%0t: locked=%b/%b err_pulse=%b/%b err_count=%h/%h",
                         $time, locked, e.locked, err_pulse, e.pulse, err_count, e.count);
            end
        end
    end

    task automatic step(input bit r, input bit v, input bit d, input bit c);
        rst_n = r; data_valid = v; data = d; clear = c;
        model_step(r, v, d, c);
        sb.push_back('{locked: (m_mode == 2), pulse: m_pulse, count: m_errs[15:0]});
        @(negedge clk);
        #1;
    endtask

    logic [6:0] g;
    task automatic gen_bit(output bit b);
        b = ^(g & taps);
        g = {g[5:0], b};
    endtask

    task automatic clean(input int n);
        bit b;
        for (int i = 0; i < n; i++) begin
            gen_bit(b);
            step(1, 1, b, 0);
        end
    endtask

    task automatic wait_lock(input string name, input bit gaps);
        bit b;
        int n = 0;
        int cyc = 0;
        while (!locked && cyc < 400) begin
            if (gaps && cyc[0]) begin
                step(1, 0, 1'($urandom_range(0, 1)), 0);
            end else begin
                gen_bit(b);
                step(1, 1, b, 0);
                n++;
            end
            cyc++;
        end
        check(name, n, 23);
    endtask

    initial begin : main_driver
        bit b;
        int pulses;
        step(0, 0, 0, 0);
        step(0, 1, 1, 1);
        check("reset_locked", locked, 0);
        check("reset_count", err_count, 0);

        g = 7'h01;
        wait_lock("lock_bits", 0);
        check("lock_count", err_count, 0);

        clean(16);
        gen_bit(b);
        step(1, 1, ~b, 0);
        check("single_pulse", err_pulse, 1);
        pulses = 1;
        for (int i = 0; i < 60; i++) begin
            clean(1);
            if (err_pulse) pulses++;
        end
        check("single_pulses", pulses, 1);
        check("single_count", err_count, 1);
        check("single_locked", locked, 1);

        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            gen_bit(b);
            step(1, 1, ~b, 0);
            if (err_pulse) pulses++;
        end
        check("loss_pulses", pulses, 4);
        check("loss_count", err_count, 5);
        check("loss_locked", locked, 0);
        wait_lock("relock_bits", 0);

        clean(5);
        gen_bit(b);
        step(1, 1, ~b, 1);
        check("clear_err_count", err_count, 0);
        check("clear_err_pulse", err_pulse, 1);
        clean(10);

        step(0, 0, 0, 0);
        for (int i = 0; i < 100; i++) step(1, 1, 0, 0);
        check("zero_locked", locked, 0);
        check("zero_count", err_count, 0);

        step(0, 0, 0, 0);
        g = 7'h01;
        wait_lock("gap_lock_bits", 1);
        clean(3);
        gen_bit(b);
        step(1, 1, ~b, 0);
        check("gap_err_count", err_count, 1);
        step(0, 1, 1, 0);
        check("rst_locked", locked, 0);
        check("rst_pulse", err_pulse, 0);
        check("rst_count", err_count, 0);

        g = 7'h01;
        for (int i = 0; i < 3000; i++) begin
            bit v = ($urandom_range(0, 3) != 0);
            bit c = ($urandom_range(0, 99) == 0);
            bit r = ($urandom_range(0, 499) != 0);
            if (v) begin
                gen_bit(b);
                if ($urandom_range(0, 19) == 0) b = ~b;
            end else begin
                b = 1'($urandom_range(0, 1));
            end
            step(r, v, b, c);
        end
        main_done = 1;
    end

    task automatic s_step(input bit r, input bit v, input bit d, input bit c);
        s_rst_n = r; s_data_valid = v; s_data = d; s_clear = c;
        @(negedge clk);
        #1;
    endtask

    logic [6:0] gs;
    task automatic s_gen(output bit b);
        b = ^(gs & taps);
        gs = {gs[5:0], b};
    endtask

    initial begin : sat_driver
        bit b;
        int n;
        int injected;
        int pulses;
        s_step(0, 0, 0, 0);
        s_step(0, 0, 0, 0);
        gs = 7'h01;
        n = 0;
        while (!s_locked && n < 200) begin
            s_gen(b);
            s_step(1, 1, b, 0);
            n++;
        end
        check("sat_lock_bits", n, 23);

        injected = 0;
        pulses = 0;
        while (injected < 65535) begin
            for (int k = 0; k < 14 && injected < 65535; k++) begin
                s_gen(b);
                s_step(1, 1, ~b, 0);
                injected++;
                if (s_err_pulse) pulses++;
            end
            s_gen(b);
            s_step(1, 1, b, 0);
            if (s_err_pulse) pulses++;
        end
        check("sat_pulses", pulses, 65535);
        check("sat_full_count", s_err_count, 16'hFFFF);
        check("sat_locked", s_locked, 1);

        s_gen(b);
        s_step(1, 1, ~b, 0);
        check("sat_hold_count", s_err_count, 16'hFFFF);
        check("sat_hold_pulse", s_err_pulse, 1);

        s_gen(b);
        s_step(1, 1, ~b, 1);
        check("sat_clear_count", s_err_count, 0);
        check("sat_clear_pulse", s_err_pulse, 1);

        s_gen(b);
        s_step(1, 1, b, 0);
        check("sat_after_pulse", s_err_pulse, 0);
        sat_done = 1;
    end

    initial begin : finisher
        fork
            wait (main_done && sat_done);
            begin
                #3_000_000;
                errors++;
                $display("FAIL timeout: main_done=%0b sat_done=%0b", main_done, sat_done);
            end
        join_any
        @(negedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
